// File: rtl/free_list_pkg.sv
// Shared rename-stage types: physical register index and the
// retire-to-rename freed-register bundle.
package free_list_pkg;

  localparam int NUM_PREGS = 64;
  localparam int NUM_AREGS = 32;
  localparam int PREG_W    = $clog2(NUM_PREGS);
  localparam int DEPTH     = NUM_PREGS - NUM_AREGS;
  localparam int PTR_W     = $clog2(DEPTH);
  localparam int CNT_W     = $clog2(DEPTH + 1);

  typedef logic [PREG_W-1:0] pregIdx_t;

  typedef struct packed {
    logic     valid1;
    pregIdx_t reg1;
    logic     valid2;
    pregIdx_t reg2;
  } freeRegStruct;

endpackage

// File: rtl/free_list.sv
// Physical-register free list: circular FIFO of free register indices,
// two all-or-nothing allocations and two reclaims per cycle.
module free_list
  import free_list_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  freeRegStruct       free_in,
  input  logic               alloc_req1,
  input  logic               alloc_req2,
  output logic               alloc_gnt,
  output pregIdx_t           alloc_reg1,
  output pregIdx_t           alloc_reg2,
  output logic [CNT_W-1:0]   free_count,
  output logic               overflow_err
);

  // The list is a power-of-two ring so pointers wrap for free.
  initial begin
    assert (DEPTH == (1 << PTR_W))
      else $fatal(1, "free list depth must be a power of two");
  end

  pregIdx_t         entry [DEPTH];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [PTR_W-1:0] headP1;
  logic [PTR_W-1:0] tailP1;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] cntAfterAlloc;
  logic [CNT_W-1:0] room;
  logic [1:0]       nReq;
  logic [1:0]       nAlloc;
  logic [1:0]       nFree;
  logic             want1;
  logic             want2;
  logic             acc1;
  logic             acc2;
  logic             drop;
  pregIdx_t         wrA;

  // Allocation: grant only if every asserted request fits; compact
  // requests so slot 2 alone takes the head entry.
  always_comb begin
    nReq       = {1'b0, alloc_req1} + {1'b0, alloc_req2};
    alloc_gnt  = (count >= CNT_W'(nReq));
    nAlloc     = alloc_gnt ? nReq : 2'd0;
    headP1     = head + PTR_W'(1);
    alloc_reg1 = entry[head];
    alloc_reg2 = alloc_req1 ? entry[headP1] : entry[head];
  end

  // Reclaim: p0 is never freed; frees beyond the post-alloc room are
  // discarded (reg1 has priority) and flagged.
  always_comb begin
    want1 = free_in.valid1 && (free_in.reg1 != '0);
    want2 = free_in.valid2 && (free_in.reg2 != '0);
    cntAfterAlloc = count - CNT_W'(nAlloc);
    room = CNT_W'(DEPTH) - cntAfterAlloc;
    acc1 = want1 && (room != '0);
    if (acc1)
      acc2 = want2 && (room >= CNT_W'(2));
    else
      acc2 = want2 && !want1 && (room != '0);
    nFree  = {1'b0, acc1} + {1'b0, acc2};
    drop   = (want1 && !acc1) || (want2 && !acc2);
    wrA    = acc1 ? free_in.reg1 : free_in.reg2;
    tailP1 = tail + PTR_W'(1);
  end

  // Pointer, occupancy and sticky overflow state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head         <= '0;
      tail         <= '0;
      count        <= CNT_W'(DEPTH);
      overflow_err <= 1'b0;
    end else begin
      head         <= head + PTR_W'(nAlloc);
      tail         <= tail + PTR_W'(nFree);
      count        <= cntAfterAlloc + CNT_W'(nFree);
      overflow_err <= overflow_err | drop;
    end
  end

  // Ring storage; reset seeds it with every non-architectural register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++)
        entry[i] <= pregIdx_t'(NUM_AREGS + i);
    end else begin
      if (acc1 || acc2)
        entry[tail] <= wrA;
      if (acc1 && acc2)
        entry[tailP1] <= free_in.reg2;
    end
  end

  assign free_count = count;

endmodule
